// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial logic unit that applies one of eight 2-input
// bitwise operations to WIDTH-bit operands, one bit per clock, LSB first.
// Optional macro SERIAL_LU_ZERO_FLAG_EN adds a registered all-zero result flag.

// 2:1 mux made only of nand gates; y = sel ? d1 : d0.
module slu_mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);
  logic selN, t0, t1;

  nand gSelN (selN, sel, sel);
  nand gT0   (t0, d0, selN);
  nand gT1   (t1, d1, sel);
  nand gY    (y, t0, t1);
endmodule

// Single result bit: all eight candidate functions from nand/nor gates,
// then an 8:1 mux tree steered by op (op[0] at the leaves, op[2] at the root).
module slu_bit_cell (
  input  logic       aBit,
  input  logic       bBit,
  input  logic [2:0] op,
  output logic       rBit
);
  logic fAnd, fOr, fNand, fNor, fXor, fXnor, fNotA, fNotB;
  logic xa, xb;
  logic m00, m01, m02, m03, m10, m11;

  nand gNand (fNand, aBit, bBit);
  nand gAnd  (fAnd, fNand, fNand);
  nor  gNor  (fNor, aBit, bBit);
  nor  gOr   (fOr, fNor, fNor);
  // Four-nand xor reuses the shared a-nand-b term.
  nand gXa   (xa, aBit, fNand);
  nand gXb   (xb, bBit, fNand);
  nand gXor  (fXor, xa, xb);
  nand gXnor (fXnor, fXor, fXor);
  nand gNotA (fNotA, aBit, aBit);
  nand gNotB (fNotB, bBit, bBit);

  slu_mux2 uM00 (.sel(op[0]), .d0(fAnd),  .d1(fOr),   .y(m00));
  slu_mux2 uM01 (.sel(op[0]), .d0(fNand), .d1(fNor),  .y(m01));
  slu_mux2 uM02 (.sel(op[0]), .d0(fXor),  .d1(fXnor), .y(m02));
  slu_mux2 uM03 (.sel(op[0]), .d0(fNotA), .d1(fNotB), .y(m03));
  slu_mux2 uM10 (.sel(op[1]), .d0(m00),   .d1(m01),   .y(m10));
  slu_mux2 uM11 (.sel(op[1]), .d0(m02),   .d1(m03),   .y(m11));
  slu_mux2 uM20 (.sel(op[2]), .d0(m10),   .d1(m11),   .y(rBit));
endmodule

module serial_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SERIAL_LU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  stateT            state, stateNext;
  logic [WIDTH-1:0] aReg, bReg, shiftReg, shiftNext;
  logic [2:0]       opReg;
  logic [CNTW-1:0]  count;
  logic             rBit;

  // The operands rotate right each RUN cycle so bit 0 is always the current
  // bit; after WIDTH rotations they are back in their captured positions.
  slu_bit_cell uCell (.aBit(aReg[0]), .bBit(bReg[0]), .op(opReg), .rBit(rBit));

  assign shiftNext = {rBit, shiftReg[WIDTH-1:1]};

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (count == LAST) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (stateNext == RUN);
      done  <= (stateNext == DONE);
    end
  end

  // Operand capture, serial evaluation and result update on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg     <= '0;
      bReg     <= '0;
      opReg    <= '0;
      shiftReg <= '0;
      count    <= '0;
      result   <= '0;
`ifdef SERIAL_LU_ZERO_FLAG_EN
      zero     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aReg     <= a;
            bReg     <= b;
            opReg    <= op;
            shiftReg <= '0;
            count    <= '0;
          end
        end
        RUN: begin
          aReg     <= {aReg[0], aReg[WIDTH-1:1]};
          bReg     <= {bReg[0], bReg[WIDTH-1:1]};
          shiftReg <= shiftNext;
          count    <= count + 1'b1;
          if (count == LAST) begin
            result <= shiftNext;
`ifdef SERIAL_LU_ZERO_FLAG_EN
            zero   <= (shiftNext == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: directed and randomized checks of serial_logic_unit
// (WIDTH = 8) against a word-level reference model.
module tb_serial_logic_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;
`ifdef SERIAL_LU_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_logic_unit #(.WIDTH(W), .CNTW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
`ifdef SERIAL_LU_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Word-level model: the whole operation at once.
  function automatic logic [W-1:0] refOp(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return ~(x & y);
      3'd3: return ~(x | y);
      3'd4: return x ^ y;
      3'd5: return ~(x ^ y);
      3'd6: return ~x;
      default: return ~y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation, scramble inputs after capture, then check busy
  // length, the done pulse, result (and zero flag) and that result holds.
  task automatic doOp(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] exp);
    int busyCnt = 0;
    bit seen = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1; break; end
      if (busy) busyCnt++;
      @(negedge clk);
    end
    chk({tag, "_doneSeen"}, 32'(seen), 32'd1);
    chk({tag, "_busyCycles"}, 32'(busyCnt), 32'(W));
    chk({tag, "_result"}, 32'(result), 32'(exp));
    chk({tag, "_busyAtDone"}, 32'(busy), 32'd0);
`ifdef SERIAL_LU_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(zero), 32'(exp == '0));
`endif
    @(negedge clk);
    chk({tag, "_donePulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(exp));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0]   ro;
    logic [W-1:0] sweepExp [8];
    int           doneCnt;
    int           bad;
    int           t [$];

    // Reset held for 3 cycles, then 20 idle cycles with no start.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // AND latency case.
    doOp("and", 3'd0, 8'hCA, 8'h0F, 8'h0A);

    // Op sweep with a = A5, b = FF.
    sweepExp = '{8'hA5, 8'hFF, 8'h5A, 8'h00, 8'h5A, 8'hA5, 8'h5A, 8'h00};
    for (int k = 1; k < 8; k++)
      doOp($sformatf("sweep%0d", k), 3'(k), 8'hA5, 8'hFF, sweepExp[k]);

    // Start again during the 3rd RUN cycle must be ignored.
    @(negedge clk);
    op = 3'd1; a = 8'h01; b = 8'h02; start = 1'b1;
    @(negedge clk); start = 1'b0;          // RUN cycle 1
    @(negedge clk);                        // RUN cycle 2
    @(negedge clk); start = 1'b1; a = 8'hFF; // RUN cycle 3
    @(negedge clk); start = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        doneCnt++;
        chk("busyStart_result", 32'(result), 32'h03);
      end
      @(negedge clk);
    end
    chk("busyStart_doneCount", 32'(doneCnt), 32'd1);
    chk("busyStart_idle", 32'(busy), 32'd0);

    // Reset during the 4th RUN cycle of an XOR.
    op = 3'd4; a = 8'h3C; b = 8'h55; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midRst_busyBefore", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midRst_busy", 32'(busy), 32'd0);
    chk("midRst_result", 32'(result), 32'd0);
    chk("midRst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("midRst_noDone", 32'(bad), 32'd0);
    doOp("norAfterRst", 3'd3, 8'h00, 8'h00, 8'hFF);

    // Zero-flag cases (result checks apply in both builds).
    doOp("andZero", 3'd0, 8'hF0, 8'h0F, 8'h00);
    doOp("notaNonZero", 3'd6, 8'h00, 8'h5A, 8'hFF);

    // Randomized operations against the model.
    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
      doOp($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb, refOp(ro, ra, rb));
    end

    // start held high: completions every WIDTH+2 cycles.
    @(negedge clk);
    op = 3'd4; a = 8'h3C; b = 8'hFF; start = 1'b1;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done) begin
        t.push_back(cyc);
        chk($sformatf("b2b_result%0d", t.size()), 32'(result), 32'hC3);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(t.size() >= 3), 32'd1);
    if (t.size() >= 3) begin
      chk("b2b_gap1", 32'(t[1] - t[0]), 32'(W + 2));
      chk("b2b_gap2", 32'(t[2] - t[1]), 32'(W + 2));
    end
    bad = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && !done) begin bad = 0; break; end
    end
    chk("b2b_drain", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
